// File: rtl/pipe_if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register and the
// instruction field decoder.
package pipe_if_id_pkg;

   localparam int unsigned INST_W  = 26;
   localparam int unsigned PC_W    = 16;
   localparam int unsigned CNT_W   = 16;

   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM10_W = 10;
   localparam int unsigned IMM15_W = 15;
   localparam int unsigned IMM20_W = 20;

   localparam int unsigned OPC_LSB = 20;
   localparam int unsigned RD_LSB  = 15;
   localparam int unsigned RN_LSB  = 10;
   localparam int unsigned RM_LSB  = 5;

   typedef logic [INST_W-1:0] inst_t;
   typedef logic [PC_W-1:0]   pc_t;

   // Opcode 0 is NOP, so an all-zero word is a bubble.
   localparam inst_t NOP_INST = INST_W'(0);

endpackage

// File: rtl/inst_field_decode.sv
// Purely combinational slicer of an instruction word into its fields.
// Fields overlap (rd/imm20, rn/imm15, rm/imm10) and are not qualified by
// opcode; immediates are raw zero-extended slices.
// Ports:
//   inst   - instruction word
//   opcode - inst[25:20]
//   rd     - inst[19:15]
//   rn     - inst[14:10]
//   rm     - inst[9:5]
//   imm10  - inst[9:0]
//   imm15  - inst[14:0]
//   imm20  - inst[19:0]
module inst_field_decode
   import pipe_if_id_pkg::*;
(
   input  inst_t              inst,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   rn,
   output logic [REG_W-1:0]   rm,
   output logic [IMM10_W-1:0] imm10,
   output logic [IMM15_W-1:0] imm15,
   output logic [IMM20_W-1:0] imm20
);

   assign opcode = inst[OPC_LSB +: OPC_W];
   assign rd     = inst[RD_LSB  +: REG_W];
   assign rn     = inst[RN_LSB  +: REG_W];
   assign rm     = inst[RM_LSB  +: REG_W];
   assign imm10  = inst[0 +: IMM10_W];
   assign imm15  = inst[0 +: IMM15_W];
   assign imm20  = inst[0 +: IMM20_W];

endmodule

// File: rtl/pipeline_if_id.sv
// IF/ID pipeline register: captures the fetched instruction and its PC,
// supports stall (hold) and flush (bubble, flush wins), and presents the
// decoded fields of the registered word to the decode stage.
// Build option: PIPE_IF_ID_PERF_EN adds saturating stall/flush counters.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous reset, active-low
//   q            - instruction word from ROM
//   pc_count     - PC of that instruction
//   stall        - hold current contents
//   flush        - replace contents with a bubble
//   q_new        - registered instruction
//   pc_count_new - registered PC
//   valid        - registered instruction is real (not a bubble)
//   opcode/rd/rn/rm/imm10/imm15/imm20 - combinational slices of q_new
//   stall_cnt    - (PIPE_IF_ID_PERF_EN) stall-only cycles, saturating
//   flush_cnt    - (PIPE_IF_ID_PERF_EN) flush cycles, saturating
module pipeline_if_id
   import pipe_if_id_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  inst_t              q,
   input  pc_t                pc_count,
   input  logic               stall,
   input  logic               flush,
   output inst_t              q_new,
   output pc_t                pc_count_new,
   output logic               valid,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   rn,
   output logic [REG_W-1:0]   rm,
   output logic [IMM10_W-1:0] imm10,
   output logic [IMM15_W-1:0] imm15,
   output logic [IMM20_W-1:0] imm20
`ifdef PIPE_IF_ID_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   // Pipeline register: flush > stall > capture. A flushed slot still
   // carries the incoming PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_new        <= NOP_INST;
         pc_count_new <= PC_W'(0);
         valid        <= 1'b0;
      end else if (flush) begin
         q_new        <= NOP_INST;
         pc_count_new <= pc_count;
         valid        <= 1'b0;
      end else if (!stall) begin
         q_new        <= q;
         pc_count_new <= pc_count;
         valid        <= 1'b1;
      end
   end

   // Field decode of the registered word; no extra pipeline delay.
   inst_field_decode u_decode (
      .inst   (q_new),
      .opcode (opcode),
      .rd     (rd),
      .rn     (rn),
      .rm     (rm),
      .imm10  (imm10),
      .imm15  (imm15),
      .imm20  (imm20)
   );

`ifdef PIPE_IF_ID_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating event counters; a stall that coincides with a flush is
   // counted only as a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= CNT_W'(0);
         flush_cnt <= CNT_W'(0);
      end else begin
         if (flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         if (stall && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_if_id.sv
// Directed bench for pipeline_if_id: reset, capture/decode, stall, flush
// priority, PC wrap, asynchronous reset mid-stall and, when built with
// PIPE_IF_ID_PERF_EN, the stall/flush counters.
module tb_pipeline_if_id;
   import pipe_if_id_pkg::*;

   logic        clk;
   logic        rst;
   inst_t       q;
   pc_t         pc_count;
   logic        stall;
   logic        flush;
   inst_t       q_new;
   pc_t         pc_count_new;
   logic        valid;
   logic [5:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic [9:0]  imm10;
   logic [14:0] imm15;
   logic [19:0] imm20;
`ifdef PIPE_IF_ID_PERF_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipeline_if_id dut (
      .clk          (clk),
      .rst          (rst),
      .q            (q),
      .pc_count     (pc_count),
      .stall        (stall),
      .flush        (flush),
      .q_new        (q_new),
      .pc_count_new (pc_count_new),
      .valid        (valid),
      .opcode       (opcode),
      .rd           (rd),
      .rn           (rn),
      .rm           (rm),
      .imm10        (imm10),
      .imm15        (imm15),
      .imm20        (imm20)
`ifdef PIPE_IF_ID_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench must always end.
   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [25:0] eq,
                              input logic [15:0] epc, input logic ev);
      check({tag, ".q_new"}, 32'(q_new), 32'(eq));
      check({tag, ".pc"},    32'(pc_count_new), 32'(epc));
      check({tag, ".valid"}, 32'(valid), 32'(ev));
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [25:0] WORD_D = {6'd5, 5'd3, 5'd2, 5'd1, 5'd0};
   localparam logic [25:0] WORD_A = 26'h2ABCDEF;
   localparam logic [25:0] WORD_B = 26'h1234567;

   initial begin
      // Reset asserted at time 0, checked before any clock edge.
      rst = 1'b0; q = 26'h3FFFFFF; pc_count = 16'h0012; stall = 1'b0; flush = 1'b0;
      #1;
      check_state("reset", 26'h0, 16'h0, 1'b0);
      check("reset.opcode", 32'(opcode), 32'h0);
      check("reset.imm20",  32'(imm20),  32'h0);
      tick();
      check_state("reset_edge", 26'h0, 16'h0, 1'b0);

      // Capture and decode.
      rst = 1'b1; q = WORD_D; pc_count = 16'h0004;
      tick();
      check_state("capture", WORD_D, 16'h0004, 1'b1);
      check("dec.opcode", 32'(opcode), 32'd5);
      check("dec.rd",     32'(rd),     32'd3);
      check("dec.rn",     32'(rn),     32'd2);
      check("dec.rm",     32'(rm),     32'd1);
      check("dec.imm10",  32'(imm10),  32'h020);
      check("dec.imm15",  32'(imm15),  32'h0820);
      check("dec.imm20",  32'(imm20),  32'h18820);

      // Stall holds A/1 for three cycles while inputs change.
      q = WORD_A; pc_count = 16'h0001;
      tick();
      check_state("load_a", WORD_A, 16'h0001, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         q = WORD_B ^ 26'(i); pc_count = 16'(16'h0010 + i);
         tick();
         check_state("stall_hold", WORD_A, 16'h0001, 1'b1);
      end
      stall = 1'b0; q = WORD_B; pc_count = 16'h0005;
      tick();
      check_state("stall_release", WORD_B, 16'h0005, 1'b1);

      // Flush wins over stall; the PC still follows the input.
      flush = 1'b1; stall = 1'b1; q = WORD_A; pc_count = 16'h0007;
      tick();
      check_state("flush_prio", 26'h0, 16'h0007, 1'b0);
      check("flush.opcode", 32'(opcode), 32'h0);
      flush = 1'b0; stall = 1'b1; pc_count = 16'h0009;
      tick();
      check_state("bubble_hold", 26'h0, 16'h0007, 1'b0);

      // PC wrap passes straight through.
      stall = 1'b0; q = WORD_A; pc_count = 16'hFFFF;
      tick();
      check_state("pc_ffff", WORD_A, 16'hFFFF, 1'b1);
      q = WORD_B; pc_count = 16'h0000;
      tick();
      check_state("pc_wrap", WORD_B, 16'h0000, 1'b1);

      // Reset mid-stall clears immediately, without a clock edge.
      stall = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_state("async_rst", 26'h0, 16'h0, 1'b0);
      flush = 1'b1;
      tick();
      check_state("rst_ignores_ctl", 26'h0, 16'h0, 1'b0);

`ifdef PIPE_IF_ID_PERF_EN
      check("perf.rst_stall", 32'(stall_cnt), 32'h0);
      check("perf.rst_flush", 32'(flush_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b1; stall = 1'b1; flush = 1'b0;
      tick(); tick();
      stall = 1'b0; flush = 1'b1;
      tick();
      stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      tick();
      check("perf.stall_cnt", 32'(stall_cnt), 32'd2);
      check("perf.flush_cnt", 32'(flush_cnt), 32'd2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("perf.clr_stall", 32'(stall_cnt), 32'h0);
      check("perf.clr_flush", 32'(flush_cnt), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
